wb_port_arbiter: RTL and testbench

- Sequences the single register-file write port between two write-back sources: the EXE result path and the MEM load-return path.
- EXE has default priority. A starvation counter guarantees MEM a grant within a bounded time.
- Each source uses a valid/ready handshake. The losing source is stalled, never dropped.
- Sits between the EXE/MEM stages and the register file.

---
 rtl/wb_port_arbiter_pkg.sv | 25 ++
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wb_port_arbiter_starve_ctr.sv | 35 +++
 rtl/wb_port_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-back port arbiter.
package wb_pkg;

  localparam int WB_STARVE_W = 8;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_DATA_W   = 32;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    PRI_EXE = 1'b0,
    PRI_MEM = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [WB_STARVE_W-1:0] sat_inc(input logic [WB_STARVE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back bus: EXE and MEM valid/ready requests in, register-file write port out.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              exe_valid;
  logic              exe_ready;
  logic [ADDR_W-1:0] exe_rd;
  logic [DATA_W-1:0] exe_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              wb_done;
  logic              starve_active;

  modport slave (
    input  exe_valid, exe_rd, exe_data, mem_valid, mem_rd, mem_data,
    output exe_ready, mem_ready, rf_we, rf_rd_addr, rf_rd_data, wb_done, starve_active
  );

  modport master (
    output exe_valid, exe_rd, exe_data, mem_valid, mem_rd, mem_data,
    input  exe_ready, mem_ready, rf_we, rf_rd_addr, rf_rd_data, wb_done, starve_active
  );
endinterface

// File: rtl/wb_port_arbiter_starve_ctr.sv
// Saturating count of cycles MEM waited with a pending request; raises force_mem_o
// in the cycle that completes STARVE_LIMIT consecutive losses.
module wb_starve_ctr
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_valid_i,
  input  logic mem_grant_i,
  output logic force_mem_o
);

  localparam logic [WB_STARVE_W-1:0] LIMIT_M1 = WB_STARVE_W'(STARVE_LIMIT - 1);

  logic [WB_STARVE_W-1:0] cnt_q, cnt_d;
  logic                   mem_lost;

  assign mem_lost = mem_valid_i && !mem_grant_i;

  // Any cycle MEM is idle or served breaks the losing streak.
  always_comb begin
    cnt_d = '0;
    if (mem_lost) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign force_mem_o = mem_lost && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-source write-back arbiter for the register-file write port; EXE wins by default,
// MEM is guaranteed a slot after STARVE_LIMIT losses. WB_PERF_EN adds perf counters.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
`ifdef WB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [15:0]       perf_forced
`endif
);

  localparam logic [0:0] ST_PRI_EXE = 1'b0;
  localparam logic [0:0] ST_PRI_MEM = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              exe_grant, mem_grant, force_mem;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_rd_addr_q;
  logic [DATA_W-1:0] rf_rd_data_q;
  logic              wb_done_q;

  // Priority only matters when both sources request in the same cycle.
  always_comb begin
    exe_grant = 1'b0;
    mem_grant = 1'b0;
    if (!rst) begin
      if (bus.exe_valid && bus.mem_valid) begin
        if (state_q == ST_PRI_MEM) mem_grant = 1'b1;
        else                       exe_grant = 1'b1;
      end else begin
        exe_grant = bus.exe_valid;
        mem_grant = bus.mem_valid;
      end
    end
  end

  assign bus.exe_ready     = exe_grant;
  assign bus.mem_ready     = mem_grant;
  assign bus.starve_active = (state_q == ST_PRI_MEM);

  wb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk         (clk),
    .rst         (rst),
    .mem_valid_i (bus.mem_valid),
    .mem_grant_i (mem_grant),
    .force_mem_o (force_mem)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PRI_EXE: if (force_mem) state_d = ST_PRI_MEM;
      // A dropped MEM request also releases priority so EXE cannot be blocked.
      ST_PRI_MEM: if (mem_grant || !bus.mem_valid) state_d = ST_PRI_EXE;
      default:    state_d = ST_PRI_EXE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_PRI_EXE;
    else     state_q <= state_d;
  end

  always_comb begin
    win_rd   = bus.exe_rd;
    win_data = bus.exe_data;
    if (mem_grant) begin
      win_rd   = bus.mem_rd;
      win_data = bus.mem_data;
    end
  end

  // Writes to x0 are acknowledged via wb_done but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst || !(exe_grant || mem_grant)) begin
      rf_we_q      <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_rd_data_q <= '0;
      wb_done_q    <= 1'b0;
    end else begin
      rf_we_q      <= (win_rd != ADDR_W'(REG_ZERO));
      rf_rd_addr_q <= win_rd;
      rf_rd_data_q <= win_data;
      wb_done_q    <= 1'b1;
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd_addr = rf_rd_addr_q;
  assign bus.rf_rd_data = rf_rd_data_q;
  assign bus.wb_done    = wb_done_q;

`ifdef WB_PERF_EN
  logic [31:0] conflicts_q;
  logic [15:0] forced_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflicts_q <= '0;
      forced_q    <= '0;
    end else begin
      if (bus.exe_valid && bus.mem_valid && (conflicts_q != '1))
        conflicts_q <= conflicts_q + 1'b1;
      if (mem_grant && (state_q == ST_PRI_MEM) && (forced_q != '1))
        forced_q <= forced_q + 1'b1;
    end
  end

  assign perf_conflicts = conflicts_q;
  assign perf_forced    = forced_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a reference model pushes expected writes to a
// scoreboard queue as requests are driven; each scenario task pops and compares them.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int LIMIT = 4;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_port_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t      sb[$];
  wb_req_t   eq[$];
  wb_req_t   mq[$];
  wb_state_e m_state;
  int        m_cnt;
  wb_req_t   e, m;
  logic      eg, mg, sa;
  exp_t      x;
  logic [31:0] rf_shadow [32];

  always @(posedge clk) if (bus.rf_we === 1'b1) rf_shadow[bus.rf_rd_addr] <= bus.rf_rd_data;

  // Requester-side protocol: an unaccepted request must be held unchanged.
  logic    h_e = 1'b0, h_m = 1'b0;
  wb_req_t pe, pm;
  always @(negedge clk) begin
    if (!rst && h_e) begin
      tests++;
      if (bus.exe_valid !== 1'b1 || bus.exe_rd !== pe.rd || bus.exe_data !== pe.data) begin
        failed++;
        $display("[TB] FAIL hold.exe: got v=%b rd=%0d d=%h, want v=1 rd=%0d d=%h",
                 bus.exe_valid, bus.exe_rd, bus.exe_data, pe.rd, pe.data);
      end
    end
    if (!rst && h_m) begin
      tests++;
      if (bus.mem_valid !== 1'b1 || bus.mem_rd !== pm.rd || bus.mem_data !== pm.data) begin
        failed++;
        $display("[TB] FAIL hold.mem: got v=%b rd=%0d d=%h, want v=1 rd=%0d d=%h",
                 bus.mem_valid, bus.mem_rd, bus.mem_data, pm.rd, pm.data);
      end
    end
    h_e = !rst && bus.exe_valid && !bus.exe_ready;
    h_m = !rst && bus.mem_valid && !bus.mem_ready;
    pe  = '{bus.exe_valid, bus.exe_rd, bus.exe_data};
    pm  = '{bus.mem_valid, bus.mem_rd, bus.mem_data};
  end

  task automatic present(input wb_req_t pe_i, input wb_req_t pm_i);
    bus.exe_valid = pe_i.valid;
    bus.exe_rd    = pe_i.rd;
    bus.exe_data  = pe_i.data;
    bus.mem_valid = pm_i.valid;
    bus.mem_rd    = pm_i.rd;
    bus.mem_data  = pm_i.data;
  endtask

  task automatic model_reset();
    m_state = PRI_EXE;
    m_cnt   = 0;
    sb.delete();
  endtask

  task automatic model_step(input wb_req_t re, input wb_req_t rm,
                            output logic g_e, output logic g_m, output logic s_a);
    exp_t nx;
    s_a = (m_state == PRI_MEM);
    g_e = re.valid && (!rm.valid || m_state == PRI_EXE);
    g_m = rm.valid && (!re.valid || m_state == PRI_MEM);
    nx  = '{1'b0, 5'd0, 32'd0, 1'b0};
    if (g_e)      nx = '{(re.rd != REG_ZERO), re.rd, re.data, 1'b1};
    else if (g_m) nx = '{(rm.rd != REG_ZERO), rm.rd, rm.data, 1'b1};
    sb.push_back(nx);
    if (m_state == PRI_EXE) begin
      if (rm.valid && !g_m && m_cnt == LIMIT - 1) m_state = PRI_MEM;
    end else if (g_m || !rm.valid) begin
      m_state = PRI_EXE;
    end
    if (rm.valid && !g_m) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    else                  m_cnt = 0;
  endtask

  task automatic heads();
    e = '0;
    m = '0;
    if (eq.size() > 0) e = eq[0];
    if (mq.size() > 0) m = mq[0];
  endtask

  task automatic test_reset();
    string tag = "reset";
    rst = 1'b1;
    present('{1'b1, 5'd1, 32'h1}, '{1'b1, 5'd2, 32'h2});
    #1;
    tests++;
    if ({bus.exe_ready, bus.mem_ready} !== 2'b00) begin
      failed++;
      $display("[TB] FAIL %s.ready: got e/m=%b%b, want 00", tag, bus.exe_ready, bus.mem_ready);
    end
    @(posedge clk); #1;
    tests++;
    if ({bus.rf_we, bus.wb_done, bus.starve_active, bus.rf_rd_addr, bus.rf_rd_data} !== 40'd0) begin
      failed++;
      $display("[TB] FAIL %s.out: got we=%b done=%b sa=%b a=%0d d=%h, want all 0", tag,
               bus.rf_we, bus.wb_done, bus.starve_active, bus.rf_rd_addr, bus.rf_rd_data);
    end
    rst = 1'b0;
    model_reset();
    eq.push_back('{1'b1, 5'd1, 32'h1});
    mq.push_back('{1'b1, 5'd2, 32'h2});
    for (int c = 0; c < 20 && (eq.size() > 0 || mq.size() > 0); c++) begin
      heads(); present(e, m); #1;
      model_step(e, m, eg, mg, sa);
      tests++;
      if ({bus.exe_ready, bus.mem_ready, bus.starve_active} !== {eg, mg, sa}) begin
        failed++;
        $display("[TB] FAIL %s.grant c%0d: got e/m/s=%b%b%b, want %b%b%b", tag, c,
                 bus.exe_ready, bus.mem_ready, bus.starve_active, eg, mg, sa);
      end
      if (eg) eq.delete(0);
      if (mg) mq.delete(0);
      @(posedge clk); #1;
      x = sb.pop_front();
      tests++;
      if (bus.rf_we !== x.we || bus.rf_rd_addr !== x.addr || bus.rf_rd_data !== x.data || bus.wb_done !== x.done) begin
        failed++;
        $display("[TB] FAIL %s.out c%0d: got we=%b a=%0d d=%h done=%b, want we=%b a=%0d d=%h done=%b", tag, c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.wb_done, x.we, x.addr, x.data, x.done);
      end
    end
    present('0, '0);
  endtask

  task automatic test_single();
    string tag = "single";
    eq.push_back('{1'b1, 5'd7, 32'hDEADBEEF});
    for (int c = 0; c < 20 && (eq.size() > 0 || mq.size() > 0); c++) begin
      heads(); present(e, m); #1;
      model_step(e, m, eg, mg, sa);
      tests++;
      if ({bus.exe_ready, bus.mem_ready, bus.starve_active} !== {eg, mg, sa}) begin
        failed++;
        $display("[TB] FAIL %s.grant c%0d: got e/m/s=%b%b%b, want %b%b%b", tag, c,
                 bus.exe_ready, bus.mem_ready, bus.starve_active, eg, mg, sa);
      end
      if (eg) eq.delete(0);
      if (mg) mq.delete(0);
      @(posedge clk); #1;
      x = sb.pop_front();
      tests++;
      if (bus.rf_we !== x.we || bus.rf_rd_addr !== x.addr || bus.rf_rd_data !== x.data || bus.wb_done !== x.done) begin
        failed++;
        $display("[TB] FAIL %s.out c%0d: got we=%b a=%0d d=%h done=%b, want we=%b a=%0d d=%h done=%b", tag, c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.wb_done, x.we, x.addr, x.data, x.done);
      end
    end
    present('0, '0);
    @(posedge clk); #1;
    tests++;
    if (bus.wb_done !== 1'b0 || bus.rf_we !== 1'b0) begin
      failed++;
      $display("[TB] FAIL %s.idle: got we=%b done=%b, want 0 0", tag, bus.rf_we, bus.wb_done);
    end
  endtask

  task automatic test_starvation();
    string tag = "starve";
    int mcyc = -1;
    logic sa_at = 1'b0;
    for (int i = 0; i < 7; i++) eq.push_back('{1'b1, 5'(i + 1), 32'h100 + i});
    mq.push_back('{1'b1, 5'd3, 32'h55});
    for (int c = 0; c < 20 && (eq.size() > 0 || mq.size() > 0); c++) begin
      heads(); present(e, m); #1;
      model_step(e, m, eg, mg, sa);
      if (bus.mem_ready === 1'b1 && mcyc < 0) begin
        mcyc  = c;
        sa_at = bus.starve_active;
      end
      tests++;
      if ({bus.exe_ready, bus.mem_ready, bus.starve_active} !== {eg, mg, sa}) begin
        failed++;
        $display("[TB] FAIL %s.grant c%0d: got e/m/s=%b%b%b, want %b%b%b", tag, c,
                 bus.exe_ready, bus.mem_ready, bus.starve_active, eg, mg, sa);
      end
      if (eg) eq.delete(0);
      if (mg) mq.delete(0);
      @(posedge clk); #1;
      x = sb.pop_front();
      tests++;
      if (bus.rf_we !== x.we || bus.rf_rd_addr !== x.addr || bus.rf_rd_data !== x.data || bus.wb_done !== x.done) begin
        failed++;
        $display("[TB] FAIL %s.out c%0d: got we=%b a=%0d d=%h done=%b, want we=%b a=%0d d=%h done=%b", tag, c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.wb_done, x.we, x.addr, x.data, x.done);
      end
    end
    present('0, '0);
    tests++;
    if (mcyc != LIMIT || sa_at !== 1'b1) begin
      failed++;
      $display("[TB] FAIL %s.forced: got mem grant cycle %0d starve_active=%b, want cycle %0d starve_active=1",
               tag, mcyc, sa_at, LIMIT);
    end
  endtask

  task automatic test_x0_write();
    string tag = "x0";
    mq.push_back('{1'b1, 5'd0, 32'h1234});
    for (int c = 0; c < 20 && (eq.size() > 0 || mq.size() > 0); c++) begin
      heads(); present(e, m); #1;
      model_step(e, m, eg, mg, sa);
      tests++;
      if ({bus.exe_ready, bus.mem_ready, bus.starve_active} !== {eg, mg, sa}) begin
        failed++;
        $display("[TB] FAIL %s.grant c%0d: got e/m/s=%b%b%b, want %b%b%b", tag, c,
                 bus.exe_ready, bus.mem_ready, bus.starve_active, eg, mg, sa);
      end
      if (eg) eq.delete(0);
      if (mg) mq.delete(0);
      @(posedge clk); #1;
      x = sb.pop_front();
      tests++;
      if (bus.rf_we !== x.we || bus.rf_rd_addr !== x.addr || bus.rf_rd_data !== x.data || bus.wb_done !== x.done) begin
        failed++;
        $display("[TB] FAIL %s.out c%0d: got we=%b a=%0d d=%h done=%b, want we=%b a=%0d d=%h done=%b", tag, c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.wb_done, x.we, x.addr, x.data, x.done);
      end
    end
    present('0, '0);
  endtask

  task automatic test_same_rd();
    string tag = "same_rd";
    eq.push_back('{1'b1, 5'd5, 32'hA});
    mq.push_back('{1'b1, 5'd5, 32'hB});
    for (int c = 0; c < 20 && (eq.size() > 0 || mq.size() > 0); c++) begin
      heads(); present(e, m); #1;
      model_step(e, m, eg, mg, sa);
      tests++;
      if ({bus.exe_ready, bus.mem_ready, bus.starve_active} !== {eg, mg, sa}) begin
        failed++;
        $display("[TB] FAIL %s.grant c%0d: got e/m/s=%b%b%b, want %b%b%b", tag, c,
                 bus.exe_ready, bus.mem_ready, bus.starve_active, eg, mg, sa);
      end
      if (eg) eq.delete(0);
      if (mg) mq.delete(0);
      @(posedge clk); #1;
      x = sb.pop_front();
      tests++;
      if (bus.rf_we !== x.we || bus.rf_rd_addr !== x.addr || bus.rf_rd_data !== x.data || bus.wb_done !== x.done) begin
        failed++;
        $display("[TB] FAIL %s.out c%0d: got we=%b a=%0d d=%h done=%b, want we=%b a=%0d d=%h done=%b", tag, c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.wb_done, x.we, x.addr, x.data, x.done);
      end
    end
    present('0, '0);
    @(posedge clk); #1;
    tests++;
    if (rf_shadow[5] !== 32'hB) begin
      failed++;
      $display("[TB] FAIL %s.final: got r5=%h, want r5=0000000b", tag, rf_shadow[5]);
    end
  endtask

  task automatic test_back_to_back();
    string tag = "b2b";
    int cycles = 0;
    for (int i = 0; i < 4; i++) begin
      eq.push_back('{1'b1, 5'(10 + i), 32'hE000 + i});
      mq.push_back('{1'b1, 5'(20 + i), 32'hF000 + i});
    end
    for (int c = 0; c < 30 && (eq.size() > 0 || mq.size() > 0); c++) begin
      heads(); present(e, m); #1;
      model_step(e, m, eg, mg, sa);
      tests++;
      if ({bus.exe_ready, bus.mem_ready, bus.starve_active} !== {eg, mg, sa}) begin
        failed++;
        $display("[TB] FAIL %s.grant c%0d: got e/m/s=%b%b%b, want %b%b%b", tag, c,
                 bus.exe_ready, bus.mem_ready, bus.starve_active, eg, mg, sa);
      end
      if (eg) eq.delete(0);
      if (mg) mq.delete(0);
      @(posedge clk); #1;
      cycles++;
      x = sb.pop_front();
      tests++;
      if (bus.rf_we !== x.we || bus.rf_rd_addr !== x.addr || bus.rf_rd_data !== x.data || bus.wb_done !== x.done) begin
        failed++;
        $display("[TB] FAIL %s.out c%0d: got we=%b a=%0d d=%h done=%b, want we=%b a=%0d d=%h done=%b", tag, c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.wb_done, x.we, x.addr, x.data, x.done);
      end
    end
    present('0, '0);
    tests++;
    if (cycles != 8) begin
      failed++;
      $display("[TB] FAIL %s.throughput: got %0d cycles for 8 writes, want 8", tag, cycles);
    end
  endtask

  task automatic test_reset_mid();
    string tag = "reset_mid";
    int mcyc = -1;
    for (int i = 0; i < 3; i++) eq.push_back('{1'b1, 5'(8 + i), 32'hC000 + i});
    mq.push_back('{1'b1, 5'd9, 32'hD00D});
    // Build up MEM's losing streak, then reset before it can be forced through.
    for (int c = 0; c < 3; c++) begin
      heads(); present(e, m); #1;
      model_step(e, m, eg, mg, sa);
      tests++;
      if ({bus.exe_ready, bus.mem_ready, bus.starve_active} !== {eg, mg, sa}) begin
        failed++;
        $display("[TB] FAIL %s.grant c%0d: got e/m/s=%b%b%b, want %b%b%b", tag, c,
                 bus.exe_ready, bus.mem_ready, bus.starve_active, eg, mg, sa);
      end
      if (eg) eq.delete(0);
      if (mg) mq.delete(0);
      @(posedge clk); #1;
      x = sb.pop_front();
      tests++;
      if (bus.rf_we !== x.we || bus.rf_rd_addr !== x.addr || bus.rf_rd_data !== x.data || bus.wb_done !== x.done) begin
        failed++;
        $display("[TB] FAIL %s.out c%0d: got we=%b a=%0d d=%h done=%b, want we=%b a=%0d d=%h done=%b", tag, c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.wb_done, x.we, x.addr, x.data, x.done);
      end
    end
    rst = 1'b1;
    present('{1'b1, 5'd11, 32'hBAD}, '{1'b1, 5'd9, 32'hD00D});
    #1;
    tests++;
    if ({bus.exe_ready, bus.mem_ready} !== 2'b00) begin
      failed++;
      $display("[TB] FAIL %s.ready_in_rst: got e/m=%b%b, want 00", tag, bus.exe_ready, bus.mem_ready);
    end
    @(posedge clk); #1;
    tests++;
    if ({bus.rf_we, bus.wb_done, bus.starve_active, bus.rf_rd_addr, bus.rf_rd_data} !== 40'd0) begin
      failed++;
      $display("[TB] FAIL %s.out_in_rst: got we=%b done=%b sa=%b a=%0d d=%h, want all 0", tag,
               bus.rf_we, bus.wb_done, bus.starve_active, bus.rf_rd_addr, bus.rf_rd_data);
    end
    rst = 1'b0;
    model_reset();
    eq.delete();
    mq.delete();
    for (int i = 0; i < 5; i++) eq.push_back('{1'b1, 5'(12 + i), 32'hC100 + i});
    mq.push_back('{1'b1, 5'd9, 32'hD00D});
    for (int c = 0; c < 20 && (eq.size() > 0 || mq.size() > 0); c++) begin
      heads(); present(e, m); #1;
      model_step(e, m, eg, mg, sa);
      if (bus.mem_ready === 1'b1 && mcyc < 0) mcyc = c;
      tests++;
      if ({bus.exe_ready, bus.mem_ready, bus.starve_active} !== {eg, mg, sa}) begin
        failed++;
        $display("[TB] FAIL %s.grant2 c%0d: got e/m/s=%b%b%b, want %b%b%b", tag, c,
                 bus.exe_ready, bus.mem_ready, bus.starve_active, eg, mg, sa);
      end
      if (eg) eq.delete(0);
      if (mg) mq.delete(0);
      @(posedge clk); #1;
      x = sb.pop_front();
      tests++;
      if (bus.rf_we !== x.we || bus.rf_rd_addr !== x.addr || bus.rf_rd_data !== x.data || bus.wb_done !== x.done) begin
        failed++;
        $display("[TB] FAIL %s.out2 c%0d: got we=%b a=%0d d=%h done=%b, want we=%b a=%0d d=%h done=%b", tag, c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.wb_done, x.we, x.addr, x.data, x.done);
      end
    end
    present('0, '0);
    tests++;
    if (mcyc != LIMIT) begin
      failed++;
      $display("[TB] FAIL %s.streak_cleared: got mem grant cycle %0d, want %0d", tag, mcyc, LIMIT);
    end
  endtask

  initial begin
    rst = 1'b1;
    present('0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_starvation();
    test_x0_write();
    test_same_rd();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
